// File: rtl/fram_burst_ctl.sv
// Fast-RAM controller for the 68030: wait states, STERM FSM, BERR timeout.
// Define FRAM_BURST_EN to enable 68030 burst line fills (CBREQ/CBACK).
module fram_burst_ctl #(
    parameter int unsigned               FRAM_ADDR_BITS = 10,
    parameter logic [FRAM_ADDR_BITS-1:0] FRAM_BASE      = 10'h3FE,
    parameter int unsigned               WAIT_STATES    = 0,
    parameter int unsigned               BERR_TIMEOUT   = 64
) (
    input  logic        nRST,
    input  logic        DRAM_CLK,
    input  logic        nAS,
    input  logic        RnW,
    input  logic [1:0]  SIZ,
    input  logic [2:0]  FC,
    input  logic [31:0] ADDR,
    input  logic        CBREQ,
    output logic        CPU_CLK,
    output logic        STERM,
    output logic        CBACK,
    output logic        BERR,
    output logic        nFRAM_RD,
    output logic [3:0]  nFRAM_WR,
    output logic [1:0]  FRAM_A
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TERM, S_DONE} state_t;

    localparam logic [2:0] WS = 3'(WAIT_STATES);
    localparam logic [7:0] BT = 8'(BERR_TIMEOUT);

    state_t     state, nxt;
    logic       ph;
    logic [2:0] wcnt;
    logic [1:0] beat, fa;
    logic       rd_q, burst;
    logic [3:0] wmask;
    logic [7:0] bcnt;
    logic       hit, more, ld, dec, adv;
    logic       unused_ok;

    // Write-enable mask, bit 3 = byte offset 0 (D31:24)
    function automatic logic [3:0] lane_mask(input logic [1:0] siz,
                                             input logic [1:0] off);
        logic [2:0] lo, hi;
        logic [3:0] m;
        lo = {1'b0, off};
        hi = lo + ((siz == 2'b00) ? 3'd4 : {1'b0, siz});
        m  = 4'b0000;
        for (int k = 0; k < 4; k++)
            m[3-k] = (3'(k) >= lo) && (3'(k) < hi);
        return m;
    endfunction

    assign hit = !nAS && (FC[1] ^ FC[0]) &&
                 (ADDR[31 -: FRAM_ADDR_BITS] == FRAM_BASE);
    assign more      = burst && CBREQ && (beat != 2'd3);
    assign CPU_CLK   = ph;
    assign BERR      = (bcnt == BT);
    assign unused_ok = ^{FC[2], ADDR};

    always_ff @(posedge DRAM_CLK or negedge nRST)
        if (!nRST) ph <= 1'b0;
        else       ph <= ~ph;

    always_ff @(posedge DRAM_CLK or negedge nRST)
        if (!nRST) state <= S_IDLE;
        else       state <= nxt;

    // nAS release aborts on any edge; everything else waits for CPU fall
    always_comb begin
        nxt = state;
        ld  = 1'b0;
        dec = 1'b0;
        adv = 1'b0;
        if (state != S_IDLE && nAS) begin
            nxt = S_IDLE;
        end else if (ph) begin
            unique case (state)
                S_IDLE: if (hit) begin
                    nxt = S_WAIT;
                    ld  = 1'b1;
                end
                S_WAIT: if (wcnt == 3'd0) nxt = S_TERM;
                        else              dec = 1'b1;
                S_TERM: if (more) begin
                    nxt = S_WAIT;
                    adv = 1'b1;
                end else begin
                    nxt = S_DONE;
                end
                S_DONE: nxt = S_DONE;
            endcase
        end
    end

    always_ff @(posedge DRAM_CLK or negedge nRST) begin
        if (!nRST) begin
            wcnt  <= '0;
            beat  <= '0;
            fa    <= '0;
            rd_q  <= 1'b0;
            wmask <= '0;
            burst <= 1'b0;
        end else if (ld) begin
            wcnt  <= WS;
            beat  <= 2'd0;
            fa    <= ADDR[3:2];
            rd_q  <= RnW;
            wmask <= lane_mask(SIZ, ADDR[1:0]);
`ifdef FRAM_BURST_EN
            burst <= CBREQ & RnW;
`else
            burst <= 1'b0;
`endif
        end else if (dec) begin
            wcnt <= wcnt - 3'd1;
        end else if (adv) begin
            wcnt <= WS;
            beat <= beat + 2'd1;
            fa   <= fa + 2'd1;
        end
    end

    always_comb begin
        STERM    = (state == S_TERM);
        CBACK    = 1'b0;
        nFRAM_RD = 1'b1;
        nFRAM_WR = 4'hF;
        FRAM_A   = (state == S_IDLE) ? ADDR[3:2] : fa;
        if (state == S_WAIT || state == S_TERM) begin
            if (rd_q) nFRAM_RD = 1'b0;
            else      nFRAM_WR = ~wmask;
`ifdef FRAM_BURST_EN
            CBACK = burst && (STERM || beat != 2'd0);
`endif
        end
    end

    always_ff @(posedge DRAM_CLK or negedge nRST)
        if (!nRST)                  bcnt <= '0;
        else if (nAS)               bcnt <= '0;
        else if (!ph && bcnt != BT) bcnt <= bcnt + 8'd1;

endmodule

// File: tb/tb_fram_burst_ctl.sv
// Bench for fram_burst_ctl: vector table, STERM scoreboard, corner sequences.
// Build with FRAM_BURST_EN to exercise burst line fills.
`timescale 1ns/1ps
module tb_fram_burst_ctl;

    logic        nRST, DRAM_CLK, nAS, RnW, CBREQ;
    logic [1:0]  SIZ;
    logic [2:0]  FC;
    logic [31:0] ADDR;

    logic       clk0, st0, cb0, be0, rd0;
    logic [3:0] wr0;
    logic [1:0] fa0;
    logic       clk2, st2, cb2, be2, rd2;
    logic [3:0] wr2;
    logic [1:0] fa2;
    logic       clk4, st4, cb4, be4, rd4;
    logic [3:0] wr4;
    logic [1:0] fa4;

    int checks = 0;
    int errors = 0;
    logic bph;
    logic sb_on = 1'b0;
    logic st_q = 1'b0;

    typedef struct packed {
        logic       rd;
        logic [3:0] wr;
        logic [1:0] fa;
        logic       cback;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  fc;
        logic        rnw;
        logic [1:0]  siz;
        logic        hit;
        logic [3:0]  wr;
        logic [1:0]  fa;
    } vec_t;
    vec_t vt[15];

    fram_burst_ctl #(.WAIT_STATES(0)) u0 (
        .nRST(nRST), .DRAM_CLK(DRAM_CLK), .nAS(nAS), .RnW(RnW),
        .SIZ(SIZ), .FC(FC), .ADDR(ADDR), .CBREQ(CBREQ),
        .CPU_CLK(clk0), .STERM(st0), .CBACK(cb0), .BERR(be0),
        .nFRAM_RD(rd0), .nFRAM_WR(wr0), .FRAM_A(fa0));

    fram_burst_ctl #(.WAIT_STATES(2)) u2 (
        .nRST(nRST), .DRAM_CLK(DRAM_CLK), .nAS(nAS), .RnW(RnW),
        .SIZ(SIZ), .FC(FC), .ADDR(ADDR), .CBREQ(CBREQ),
        .CPU_CLK(clk2), .STERM(st2), .CBACK(cb2), .BERR(be2),
        .nFRAM_RD(rd2), .nFRAM_WR(wr2), .FRAM_A(fa2));

    fram_burst_ctl #(.WAIT_STATES(4)) u4 (
        .nRST(nRST), .DRAM_CLK(DRAM_CLK), .nAS(nAS), .RnW(RnW),
        .SIZ(SIZ), .FC(FC), .ADDR(ADDR), .CBREQ(CBREQ),
        .CPU_CLK(clk4), .STERM(st4), .CBACK(cb4), .BERR(be4),
        .nFRAM_RD(rd4), .nFRAM_WR(wr4), .FRAM_A(fa4));

    initial DRAM_CLK = 1'b0;
    always #10 DRAM_CLK = ~DRAM_CLK;

    always @(posedge DRAM_CLK or negedge nRST)
        if (!nRST) bph <= 1'b0;
        else       bph <= ~bph;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge DRAM_CLK);
        #1;
    endtask

    task automatic to_rise();
        do tick(); while (bph != 1'b1);
    endtask

    task automatic to_fall();
        do tick(); while (bph != 1'b0);
    endtask

    // Scoreboard: each STERM leading edge on u0 pops one expected beat
    always @(negedge DRAM_CLK) begin
        if (sb_on && st0 && !st_q) begin
            if (sbq.size() == 0) begin
                check("sb_stray_sterm", 32'(st0), 32'd0);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                check("sb_beat", 32'({rd0, wr0, fa0, cb0}), 32'(e));
            end
        end
        st_q = st0;
    end

    task automatic run_vec(input vec_t v, input int idx);
        int act_n, st_n, st_first;
        sb_t e;
        act_n = 0;
        st_n = 0;
        st_first = 0;
        to_rise();
        ADDR = v.addr;
        FC = v.fc;
        RnW = v.rnw;
        SIZ = v.siz;
        CBREQ = 1'b0;
        nAS = 1'b0;
        if (v.hit) begin
            e.rd = v.rnw ? 1'b0 : 1'b1;
            e.wr = v.wr;
            e.fa = v.fa;
            e.cback = 1'b0;
            sbq.push_back(e);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (rd0 == 1'b0 || wr0 != 4'hF) act_n++;
            if (st0) begin
                st_n++;
                if (st_first == 0) st_first = k;
            end
        end
        check($sformatf("v%0d_strobe_len", idx), act_n, v.hit ? 4 : 0);
        check($sformatf("v%0d_sterm_len", idx), st_n, v.hit ? 2 : 0);
        check($sformatf("v%0d_sterm_at", idx), st_first, v.hit ? 3 : 0);
        nAS = 1'b1;
        tick();
        check($sformatf("v%0d_idle", idx), {rd0, wr0, st0, fa0},
              {1'b1, 4'hF, 1'b0, v.addr[3:2]});
    endtask

    task automatic run_burst(input bit drop, input int beats, input int cb);
        int st_n, cb_n;
        logic prev;
        sb_t e;
        st_n = 0;
        cb_n = 0;
        prev = 1'b0;
        to_rise();
        ADDR = 32'hFF80_0008;
        FC = 3'b101;
        RnW = 1'b1;
        SIZ = 2'b00;
        CBREQ = 1'b1;
        nAS = 1'b0;
        for (int b = 0; b < beats; b++) begin
            e.rd = 1'b0;
            e.wr = 4'hF;
            e.fa = 2'(2 + b);
            e.cback = (cb != 0);
            sbq.push_back(e);
        end
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (st0 && !prev) st_n++;
            if (drop && prev && !st0) CBREQ = 1'b0;
            prev = st0;
            if (cb0) cb_n++;
        end
        check($sformatf("burst%0d_beats", drop), st_n, beats);
        check($sformatf("burst%0d_cback_len", drop), cb_n, cb);
        check($sformatf("burst%0d_done", drop), {cb0, rd0}, {1'b0, 1'b1});
        nAS = 1'b1;
        CBREQ = 1'b0;
        tick();
    endtask

    initial begin
        int n, act, st_n, st_first, bad, first;
        nRST = 1'b0;
        nAS = 1'b1;
        RnW = 1'b1;
        SIZ = 2'b00;
        FC = 3'b001;
        ADDR = 32'h0000_000C;
        CBREQ = 1'b0;

        vt[0]  = '{32'hFF80_0000, 3'b001, 1'b1, 2'b00, 1'b1, 4'hF,    2'd0};
        vt[1]  = '{32'hFF80_0001, 3'b101, 1'b0, 2'b10, 1'b1, 4'b1001, 2'd0};
        vt[2]  = '{32'hFF80_0003, 3'b010, 1'b0, 2'b01, 1'b1, 4'b1110, 2'd0};
        vt[3]  = '{32'hFF80_0004, 3'b110, 1'b0, 2'b00, 1'b1, 4'b0000, 2'd1};
        vt[4]  = '{32'hFF80_0009, 3'b001, 1'b0, 2'b11, 1'b1, 4'b1000, 2'd2};
        vt[5]  = '{32'hFF80_0002, 3'b101, 1'b0, 2'b10, 1'b1, 4'b1100, 2'd0};
        vt[6]  = '{32'hFFBF_FFFE, 3'b001, 1'b0, 2'b00, 1'b1, 4'b1100, 2'd3};
        vt[7]  = '{32'hFF80_0000, 3'b001, 1'b0, 2'b01, 1'b1, 4'b0111, 2'd0};
        vt[8]  = '{32'hFF80_000F, 3'b101, 1'b0, 2'b11, 1'b1, 4'b1110, 2'd3};
        vt[9]  = '{32'hFF80_0006, 3'b110, 1'b1, 2'b01, 1'b1, 4'hF,    2'd1};
        vt[10] = '{32'hFFC0_0000, 3'b001, 1'b1, 2'b00, 1'b0, 4'hF,    2'd0};
        vt[11] = '{32'hFF7F_FFFC, 3'b001, 1'b1, 2'b00, 1'b0, 4'hF,    2'd3};
        vt[12] = '{32'hFF80_0000, 3'b111, 1'b1, 2'b00, 1'b0, 4'hF,    2'd0};
        vt[13] = '{32'hFF80_0000, 3'b000, 1'b0, 2'b00, 1'b0, 4'hF,    2'd0};
        vt[14] = '{32'hFF80_0005, 3'b010, 1'b0, 2'b10, 1'b1, 4'b1001, 2'd1};

        #5;
        check("rst_outputs", {clk0, st0, cb0, be0, rd0, wr0, fa0},
              {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 2'd3});
        #20;
        nRST = 1'b1;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (clk0 !== bph) bad++;
        end
        check("cpu_clk_div", bad, 0);

        sb_on = 1'b1;
        for (int i = 0; i < 15; i++) run_vec(vt[i], i);

`ifdef FRAM_BURST_EN
        run_burst(1'b0, 4, 14);
        run_burst(1'b1, 2, 6);
`else
        run_burst(1'b0, 1, 0);
`endif
        repeat (4) tick();
        check("sb_empty", sbq.size(), 0);
        sb_on = 1'b0;

        // WAIT_STATES=2 byte write
        act = 0;
        st_n = 0;
        st_first = 0;
        bad = 0;
        to_rise();
        ADDR = 32'hFF80_0003;
        FC = 3'b001;
        RnW = 1'b0;
        SIZ = 2'b01;
        nAS = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (wr2 == 4'b1110) act++;
            else if (wr2 != 4'hF) bad++;
            if (rd2 == 1'b0) bad++;
            if (st2) begin
                st_n++;
                if (st_first == 0) st_first = k;
            end
        end
        check("ws2_strobe_len", act, 8);
        check("ws2_bad_strobe", bad, 0);
        check("ws2_sterm_len", st_n, 2);
        check("ws2_sterm_at", st_first, 7);
        nAS = 1'b1;
        tick();
        check("ws2_idle", {rd2, wr2, st2}, {1'b1, 4'hF, 1'b0});

        // Abort in WAIT on a CPU-rise edge
        to_rise();
        ADDR = 32'hFF80_0010;
        FC = 3'b101;
        RnW = 1'b1;
        SIZ = 2'b00;
        nAS = 1'b0;
        to_fall();
        tick();
        tick();
        check("abort_pre", rd4, 1'b0);
        nAS = 1'b1;
        #15;
        check("abort_hold", rd4, 1'b0);
        tick();
        check("abort_release", {rd4, wr4, st4}, {1'b1, 4'hF, 1'b0});
        n = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (st4) n++;
        end
        check("abort_no_sterm", n, 0);

        // Bus-error timeout on a non-hit
        to_rise();
        ADDR = 32'h0000_1000;
        FC = 3'b001;
        RnW = 1'b1;
        nAS = 1'b0;
        first = 0;
        act = 0;
        for (int k = 1; k <= 70; k++) begin
            to_rise();
            if (be0 && first == 0) first = k;
            if (rd0 == 1'b0 || wr0 != 4'hF || st0) act++;
        end
        check("berr_first", first, 64);
        check("berr_held", be0, 1'b1);
        check("berr_no_strobe", act, 0);
        nAS = 1'b1;
        #15;
        check("berr_pre_clear", be0, 1'b1);
        tick();
        check("berr_clear", be0, 1'b0);

        // Reset asserted mid-WAIT
        to_rise();
        ADDR = 32'hFF80_0004;
        FC = 3'b001;
        RnW = 1'b0;
        SIZ = 2'b00;
        nAS = 1'b0;
        to_fall();
        tick();
        tick();
        check("rst_pre", wr4, 4'b0000);
        #5;
        nRST = 1'b0;
        #1;
        check("rst_mid_wait", {clk4, st4, cb4, be4, rd4, wr4, fa4},
              {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 2'd1});
        nAS = 1'b1;
        #3;
        nRST = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
